// File: rtl/lsu_sequencer_if.sv
// Data-memory port between lsu_sequencer (master) and memory (slave):
// request/byte-enable/write-data outward, ready/rvalid/rdata inward.
interface lsu_sequencer_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                    mem_req;
   logic                    mem_we;
   logic [ADDR_WIDTH-1:0]   mem_addr;
   logic [DATA_WIDTH/8-1:0] mem_be;
   logic [DATA_WIDTH-1:0]   mem_wdata;
   logic                    mem_ready;
   logic                    mem_rvalid;
   logic [DATA_WIDTH-1:0]   mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      input  mem_ready, mem_rvalid, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      output mem_ready, mem_rvalid, mem_rdata
   );
endinterface

// File: rtl/lsu_sequencer.sv
// Load/store sequencer: word-aligned bus request with byte enables, core stall, extended load result.
// Define MISALIGN_TRAP_EN to trap misaligned halfword/word accesses instead of issuing them.
module lsu_sequencer #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  dmem_read_en,
   input  logic                  dmem_write_en,
   input  logic [2:0]            func3,
   input  logic [ADDR_WIDTH-1:0] alu_addr,
   input  logic [DATA_WIDTH-1:0] rs2_data,
   output logic                  stall,
   output logic                  load_done,
   output logic [DATA_WIDTH-1:0] load_data,
   output logic                  misalign,
   lsu_sequencer_if.master       mem
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_e;
   typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;

   state_e                  state_q, state_d;
   size_e                   size_q, size_d, size_c;
   logic                    uns_q, uns_d;
   logic [1:0]              off_q, off_d;
   logic                    mem_req_q, mem_req_d;
   logic                    mem_we_q, mem_we_d;
   logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
   logic [3:0]              mem_be_q, mem_be_d, be_c;
   logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d, wdata_c;
   logic                    load_done_q, load_done_d;
   logic [DATA_WIDTH-1:0]   load_data_q, load_data_d, ext_c;
   logic                    misalign_q, misalign_d;
   logic [7:0]              rbyte;
   logic [15:0]             rhalf;
`ifdef MISALIGN_TRAP_EN
   logic                    misal_c;
`endif

   // Loads decode bu/hu through func3[1:0]; stores only accept 000/001 as sub-word.
   always_comb begin
      size_c = SZ_W;
      if (dmem_read_en) begin
         if (func3[1:0] == 2'b00)      size_c = SZ_B;
         else if (func3[1:0] == 2'b01) size_c = SZ_H;
      end else begin
         if (func3 == 3'b000)          size_c = SZ_B;
         else if (func3 == 3'b001)     size_c = SZ_H;
      end
      be_c    = 4'b1111;
      wdata_c = rs2_data;
      case (size_c)
         SZ_B: begin
            be_c    = 4'b0001 << alu_addr[1:0];
            wdata_c = {4{rs2_data[7:0]}};
         end
         SZ_H: begin
            be_c    = 4'b0011 << {alu_addr[1], 1'b0};
            wdata_c = {2{rs2_data[15:0]}};
         end
         default: ;
      endcase
`ifdef MISALIGN_TRAP_EN
      misal_c = ((size_c == SZ_H) && alu_addr[0]) ||
                ((size_c == SZ_W) && (alu_addr[1:0] != 2'b00));
`endif
   end

   always_comb begin
      rbyte = mem.mem_rdata[{off_q, 3'b000} +: 8];
      rhalf = mem.mem_rdata[{off_q[1], 4'b0000} +: 16];
      case (size_q)
         SZ_B:    ext_c = {{(DATA_WIDTH-8){rbyte[7] & ~uns_q}}, rbyte};
         SZ_H:    ext_c = {{(DATA_WIDTH-16){rhalf[15] & ~uns_q}}, rhalf};
         default: ext_c = mem.mem_rdata;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      size_d      = size_q;
      uns_d       = uns_q;
      off_d       = off_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_be_d    = mem_be_q;
      mem_wdata_d = mem_wdata_q;
      load_data_d = load_data_q;
      misalign_d  = 1'b0;
      stall       = 1'b0;
      case (state_q)
         IDLE: begin
            if (dmem_read_en || dmem_write_en) begin
               stall       = 1'b1;
               state_d     = REQ;
               mem_we_d    = ~dmem_read_en;
               mem_addr_d  = {alu_addr[ADDR_WIDTH-1:2], 2'b00};
               mem_be_d    = be_c;
               mem_wdata_d = wdata_c;
               size_d      = size_c;
               uns_d       = func3[2];
               off_d       = alu_addr[1:0];
`ifdef MISALIGN_TRAP_EN
               if (misal_c) begin
                  state_d     = DONE;
                  misalign_d  = 1'b1;
                  load_data_d = '0;
               end
`endif
            end
         end
         REQ: begin
            stall = 1'b1;
            if (mem.mem_ready) state_d = mem_we_q ? DONE : WAIT_R;
         end
         WAIT_R: begin
            stall = 1'b1;
            if (mem.mem_rvalid) begin
               load_data_d = ext_c;
               state_d     = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
      // Registered outputs are derived from the next state so they align with it.
      mem_req_d   = (state_d == REQ);
      load_done_d = (state_d == DONE) && !mem_we_d && !misalign_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         size_q      <= SZ_B;
         uns_q       <= 1'b0;
         off_q       <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_be_q    <= '0;
         mem_wdata_q <= '0;
         load_done_q <= 1'b0;
         load_data_q <= '0;
         misalign_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         size_q      <= size_d;
         uns_q       <= uns_d;
         off_q       <= off_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_be_q    <= mem_be_d;
         mem_wdata_q <= mem_wdata_d;
         load_done_q <= load_done_d;
         load_data_q <= load_data_d;
         misalign_q  <= misalign_d;
      end
   end

   assign mem.mem_req   = mem_req_q;
   assign mem.mem_we    = mem_we_q;
   assign mem.mem_addr  = mem_addr_q;
   assign mem.mem_be    = mem_be_q;
   assign mem.mem_wdata = mem_wdata_q;
   assign load_done     = load_done_q;
   assign load_data     = load_data_q;
   assign misalign      = misalign_q;

endmodule
